logo_mem_arbiter: RTL and testbench

- Shares the single-port 16 KiB logo/FM memory (14-bit address, 8-bit data, synchronous write, 1-cycle registered read) between two requesters.
- Requester C is the CPU slot decoder; requester L is the boot loader / DMA filler.
- Grants at most one access per clock and drives the memory port from registers.
- Returns read data to the owning requester with a fixed latency.

---
 rtl/logo_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_logo_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logo_mem_arbiter.sv
// logo_mem_arbiter
// Arbitrates the single-port logo/FM memory between the CPU slot decoder (C)
// and the boot loader / DMA filler (L). At most one access is granted per
// clock. The memory port is driven from registers. Read data goes back to
// the owning requester 3 cycles after its grant.
// Optional build macro: CPU_PRIORITY_EN gives C fixed priority. It replaces
// the default round-robin.
module logo_mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    // CPU slot requester
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,
    // Loader requester
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_rvalid,
    // Memory port
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_L = 1'b1
    } owner_e;

    logic   w_c_grant;
    logic   w_l_grant;
    logic   w_rd_grant;

    // Read-tracking pipeline: stage 1 covers the memory sample cycle.
    // Stage 2 covers the cycle in which mem_q is valid.
    logic   r_s1_rd;
    owner_e r_s1_own;
    logic   r_s2_rd;
    owner_e r_s2_own;

`ifdef CPU_PRIORITY_EN
    // Fixed priority: C wins every conflict; acks are suppressed during reset
    always_comb begin
        w_c_grant = 1'b0;
        w_l_grant = 1'b0;
        if (!reset) begin
            w_c_grant = c_req;
            w_l_grant = l_req & ~c_req;
        end
    end
`else
    owner_e r_last_grant;

    // Round-robin: on a conflict, grant the requester that did not win last
    always_comb begin
        w_c_grant = 1'b0;
        w_l_grant = 1'b0;
        if (!reset) begin
            if (c_req && l_req) begin
                if (r_last_grant == OWN_L) begin
                    w_c_grant = 1'b1;
                end else begin
                    w_l_grant = 1'b1;
                end
            end else begin
                w_c_grant = c_req;
                w_l_grant = l_req;
            end
        end
    end

    // Remember the last winner; it only changes on a grant
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= OWN_L;
        end else if (w_c_grant) begin
            r_last_grant <= OWN_C;
        end else if (w_l_grant) begin
            r_last_grant <= OWN_L;
        end
    end
`endif

    assign c_ack      = w_c_grant;
    assign l_ack      = w_l_grant;
    assign w_rd_grant = (w_c_grant & ~c_we) | (w_l_grant & ~l_we);

    // Stage 0: load the memory port from the granted requester
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
        end else if (w_c_grant) begin
            mem_address <= c_addr;
            mem_data    <= c_wdata;
            mem_wren    <= c_we;
        end else if (w_l_grant) begin
            mem_address <= l_addr;
            mem_data    <= l_wdata;
            mem_wren    <= l_we;
        end else begin
            mem_wren    <= 1'b0;
        end
    end

    // Stages 1-2: carry owner and is-read alongside the memory latency
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_rd  <= 1'b0;
            r_s1_own <= OWN_C;
            r_s2_rd  <= 1'b0;
            r_s2_own <= OWN_C;
        end else begin
            r_s1_rd  <= w_rd_grant;
            r_s1_own <= w_l_grant ? OWN_L : OWN_C;
            r_s2_rd  <= r_s1_rd;
            r_s2_own <= r_s1_own;
        end
    end

    // Completion: capture mem_q into the owner's rdata and pulse its rvalid
    always_ff @(posedge clock) begin
        if (reset) begin
            c_rdata  <= '0;
            c_rvalid <= 1'b0;
            l_rdata  <= '0;
            l_rvalid <= 1'b0;
        end else begin
            c_rvalid <= r_s2_rd && (r_s2_own == OWN_C);
            l_rvalid <= r_s2_rd && (r_s2_own == OWN_L);
            if (r_s2_rd && (r_s2_own == OWN_C)) begin
                c_rdata <= mem_q;
            end
            if (r_s2_rd && (r_s2_own == OWN_L)) begin
                l_rdata <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_logo_mem_arbiter.sv
// Testbench for logo_mem_arbiter.
// It runs a table of per-cycle vectors and hand-written multi-cycle sequences.
// A read scoreboard, fed at ack time, checks data, latency and ordering.
// Expectations follow the CPU_PRIORITY_EN build selection.
module tb_logo_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_req, c_we, l_req, l_we;
    logic [13:0] c_addr, l_addr;
    logic [7:0]  c_wdata, l_wdata;
    logic        c_ack, l_ack, c_rvalid, l_rvalid;
    logic [7:0]  c_rdata, l_rdata;
    logic [13:0] mem_address;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  mem_q;

    logo_mem_arbiter #(.ADDR_W(14), .DATA_W(8)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Memory: synchronous write, registered read
    logic [7:0] ram [0:16383];
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] pre(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } rd_t;

    typedef struct {
        logic        rst;
        logic        creq, cwe;
        logic [13:0] caddr;
        logic [7:0]  cwd;
        logic        lreq, lwe;
        logic [13:0] laddr;
        logic [7:0]  lwd;
        logic        exp_cack, exp_lack;
    } vec_t;

    logic [7:0] model_mem [0:16383];
    rd_t        qc[$];
    rd_t        ql[$];
    logic [7:0] exp_c = '0;
    logic [7:0] exp_l = '0;
    logic       seen_rst = 1'b0;
    logic       s_cack, s_lack;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle scoreboard work, run at the falling edge
    task automatic sb_cycle();
        rd_t e;
        s_cack = c_ack;
        s_lack = l_ack;
        if (seen_rst) begin
            chk("ack_exclusive", {31'd0, s_cack & s_lack}, 32'd0);
            if (c_rvalid) begin
                if (qc.size() == 0) chk("c_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    e = qc.pop_front();
                    chk("c_rdata", {24'd0, c_rdata}, {24'd0, e.data});
                    chk("c_latency", cyc - e.cyc, 32'd3);
                    exp_c = e.data;
                end
            end else chk("c_rdata_hold", {24'd0, c_rdata}, {24'd0, exp_c});
            if (l_rvalid) begin
                if (ql.size() == 0) chk("l_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    e = ql.pop_front();
                    chk("l_rdata", {24'd0, l_rdata}, {24'd0, e.data});
                    chk("l_latency", cyc - e.cyc, 32'd3);
                    exp_l = e.data;
                end
            end else chk("l_rdata_hold", {24'd0, l_rdata}, {24'd0, exp_l});
        end
        if (reset) begin
            qc.delete();
            ql.delete();
            exp_c    = '0;
            exp_l    = '0;
            seen_rst = 1'b1;
        end else begin
            if (s_cack) begin
                if (c_we) model_mem[c_addr] = c_wdata;
                else qc.push_back('{data: model_mem[c_addr], cyc: cyc});
            end
            if (s_lack) begin
                if (l_we) model_mem[l_addr] = l_wdata;
                else ql.push_back('{data: model_mem[l_addr], cyc: cyc});
            end
        end
    endtask

    // Advance one cycle; returns 1 time unit after the next rising edge
    task automatic tick();
        @(negedge clock);
        sb_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input vec_t v);
        reset   = v.rst;
        c_req   = v.creq;  c_we = v.cwe;  c_addr = v.caddr; c_wdata = v.cwd;
        l_req   = v.lreq;  l_we = v.lwe;  l_addr = v.laddr; l_wdata = v.lwd;
    endtask

    task automatic idle();
        reset = 1'b0; c_req = 1'b0; l_req = 1'b0;
        c_we = 1'b0; l_we = 1'b0;
    endtask

    task automatic drain(input string name);
        idle();
        for (int k = 0; k < 20 && (qc.size() + ql.size()) != 0; k++) tick();
        chk(name, qc.size() + ql.size(), 32'd0);
        tick();
    endtask

    vec_t vecs[14];
    logic prev_wr;
    logic [13:0] prev_addr;
    logic [7:0]  prev_data;
    logic        prio;
    int          c_grants;
    logic        last_own_l;
    logic [13:0] ca, la;

    initial begin
`ifdef CPU_PRIORITY_EN
        prio = 1'b1;
`else
        prio = 1'b0;
`endif
        for (int a = 0; a < 16384; a++) begin
            ram[a]       = pre(14'(a));
            model_mem[a] = pre(14'(a));
        end
        //            rst creq cwe caddr     cwd    lreq lwe laddr     lwd    cack   lack
        vecs[0]  = '{1'b1, 1, 0, 14'h0010, 8'h00, 1, 0, 14'h0020, 8'h00, 0,     0};
        vecs[1]  = '{1'b1, 1, 0, 14'h0010, 8'h00, 1, 0, 14'h0020, 8'h00, 0,     0};
        vecs[2]  = '{1'b0, 1, 0, 14'h0010, 8'h00, 1, 0, 14'h0020, 8'h00, 1,     0};
        vecs[3]  = '{1'b0, 1, 0, 14'h0011, 8'h00, 1, 0, 14'h0020, 8'h00, prio,  !prio};
        vecs[4]  = '{1'b0, 0, 0, 14'h0000, 8'h00, 1, 1, 14'h0123, 8'h5A, 0,     1};
        vecs[5]  = '{1'b0, 1, 0, 14'h0123, 8'h00, 0, 0, 14'h0000, 8'h00, 1,     0};
        vecs[6]  = '{1'b0, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0,     0};
        vecs[7]  = '{1'b0, 1, 1, 14'h0200, 8'h33, 0, 0, 14'h0000, 8'h00, 1,     0};
        vecs[8]  = '{1'b0, 1, 0, 14'h3FFF, 8'h00, 1, 0, 14'h0200, 8'h00, prio,  !prio};
        vecs[9]  = '{1'b0, 1, 0, 14'h3FFF, 8'h00, 0, 0, 14'h0000, 8'h00, 1,     0};
        vecs[10] = '{1'b0, 1, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 1,     0};
        vecs[11] = '{1'b0, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0,     0};
        vecs[12] = '{1'b0, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0,     0};
        vecs[13] = '{1'b0, 0, 0, 14'h0000, 8'h00, 0, 0, 14'h0000, 8'h00, 0,     0};

        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Table-driven vectors
        prev_wr = 1'b0; prev_addr = '0; prev_data = '0;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i]);
            if (i == 1) begin
                chk("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
                chk("rst_mem_address", {18'd0, mem_address}, 32'd0);
                chk("rst_mem_data", {24'd0, mem_data}, 32'd0);
                chk("rst_rvalid", {30'd0, c_rvalid, l_rvalid}, 32'd0);
                chk("rst_rdata", {16'd0, c_rdata, l_rdata}, 32'd0);
            end else if (i > 1) begin
                chk($sformatf("v%0d_mem_wren", i), {31'd0, mem_wren}, {31'd0, prev_wr});
                if (prev_wr) begin
                    chk($sformatf("v%0d_mem_address", i), {18'd0, mem_address}, {18'd0, prev_addr});
                    chk($sformatf("v%0d_mem_data", i), {24'd0, mem_data}, {24'd0, prev_data});
                end
            end
            tick();
            chk($sformatf("v%0d_c_ack", i), {31'd0, s_cack}, {31'd0, vecs[i].exp_cack});
            chk($sformatf("v%0d_l_ack", i), {31'd0, s_lack}, {31'd0, vecs[i].exp_lack});
            prev_wr   = !vecs[i].rst && ((vecs[i].exp_cack && vecs[i].cwe) ||
                                         (vecs[i].exp_lack && vecs[i].lwe));
            prev_addr = vecs[i].exp_cack ? vecs[i].caddr : vecs[i].laddr;
            prev_data = vecs[i].exp_cack ? vecs[i].cwd : vecs[i].lwd;
        end
        drain("table_drain");

        // Both sides streaming reads (RR) / fixed priority under contention
        idle();
        c_req = 1'b1; l_req = 1'b1;
        if (!prio) begin
            ca = 14'h0000; la = 14'h3FFF; c_grants = 0; last_own_l = 1'b0;
            for (int k = 0; k < 16; k++) begin
                c_addr = ca; l_addr = la;
                tick();
                chk("stream_one_ack", {30'd0, s_cack, s_lack}, s_cack ? 32'd2 : 32'd1);
                if (k > 0) chk("stream_alternate", {31'd0, s_lack}, {31'd0, !last_own_l});
                last_own_l = s_lack;
                if (s_cack) begin ca = ca + 14'd1; c_grants++; end
                if (s_lack) la = la - 14'd1;
            end
            chk("stream_c_grants", c_grants, 32'd8);
        end else begin
            c_addr = 14'h0000; l_addr = 14'h3FFF;
            for (int k = 0; k < 10; k++) begin
                tick();
                chk("prio_c_ack", {31'd0, s_cack}, 32'd1);
                chk("prio_l_ack", {31'd0, s_lack}, 32'd0);
                c_addr = c_addr + 14'd1;
            end
            c_req = 1'b0;
            tick();
            chk("prio_l_after_c_drop", {31'd0, s_lack}, 32'd1);
        end
        drain("stream_drain");

        // Reset in the cycle after a read ack discards the read
        idle();
        c_req = 1'b1; c_addr = 14'h0123;
        tick();
        chk("rr_ack_before_reset", {31'd0, s_cack}, 32'd1);
        idle();
        reset = 1'b1;
        tick();
        chk("ack_during_reset", {30'd0, s_cack, s_lack}, 32'd0);
        idle();
        for (int k = 0; k < 5; k++) tick();
        chk("c_rdata_after_reset", {24'd0, c_rdata}, 32'd0);
        c_req = 1'b1; c_addr = 14'h0010;
        tick();
        chk("post_reset_ack", {31'd0, s_cack}, 32'd1);
        drain("post_reset_drain");
        chk("post_reset_rdata", {24'd0, c_rdata}, {24'd0, pre(14'h0010)});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
